// File: rtl/disp_pkg.sv
// Shared types and helpers for the display frame sequencer.
package disp_pkg;

  typedef enum logic [1:0] {
    PACE  = 2'd0,
    LAYER = 2'd1,
    SWAP  = 2'd2
  } disp_seq_state_t;

  localparam int FRAME_CNT_W = 16;

  // Index width for an N-entry layer set, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/disp_seq_next.sv
// Finds the next enabled layer: lowest set mask bit strictly above cur,
// or the lowest set bit overall when from_start is high.
module disp_seq_next
  import disp_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] cur,
  input  logic          from_start,
  output logic          found,
  output logic [IW-1:0] next_idx
);

  // Scanning downward lets the lowest qualifying bit overwrite the rest.
  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(cur)))) begin
        found    = 1'b1;
        next_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/disp_layer_seq.sv
// Frame sequencer: runs enabled drawing layers in index order over start/done
// pulses, then requests a buffer swap, with frame pacing and a layer watchdog.
module disp_layer_seq
  import disp_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int MIN_FRAME = 0,
  parameter  int TIMEOUT   = 2**20,
  localparam int IW        = idx_w(N)
) (
  input  logic                   clkSYS,
  input  logic                   n_reset,
  input  logic [N-1:0]           layer_en,
  output logic [N-1:0]           layer_start,
  input  logic [N-1:0]           layer_done,
  output logic                   swap_start,
  input  logic                   swap_done,
  input  logic                   err_clr,
  output logic                   busy,
  output logic [IW-1:0]          cur_layer,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [N-1:0]           err_to
);

  localparam int FT_W = (MIN_FRAME > 0) ? $clog2(MIN_FRAME + 1) : 1;
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [FT_W-1:0] FT_MAX = FT_W'(MIN_FRAME);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  disp_seq_state_t        state_q, state_d;
  logic [N-1:0]           mask_q, mask_d;
  logic [IW-1:0]          cur_q, cur_d;
  logic [N-1:0]           layer_start_q, layer_start_d;
  logic                   swap_start_q, swap_start_d;
  logic                   busy_q, busy_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [N-1:0]           err_to_q, err_to_d;
  logic [FT_W-1:0]        frame_tmr_q, frame_tmr_d;
  logic [WD_W-1:0]        wdog_q, wdog_d;

  logic [N-1:0]  nx_mask;
  logic          nx_from_start;
  logic          nx_found;
  logic [IW-1:0] nx_idx;
  logic [FT_W:0] tmr_plus;
  logic          pace_ok;
  logic          layer_accept;
  logic          wd_expire;

  // At PACE exit the fresh layer_en is searched from bit 0; in LAYER the
  // latched mask is searched above the current index.
  assign nx_from_start = (state_q == PACE);
  assign nx_mask       = nx_from_start ? layer_en : mask_q;

  disp_seq_next #(.N(N)) u_next (
    .mask       (nx_mask),
    .cur        (cur_q),
    .from_start (nx_from_start),
    .found      (nx_found),
    .next_idx   (nx_idx)
  );

  // The exit cycle itself counts toward the period, so with nothing to draw
  // consecutive swap_start pulses land exactly MIN_FRAME cycles apart.
  assign tmr_plus = {1'b0, frame_tmr_q} + (FT_W + 1)'(1);
  assign pace_ok  = (tmr_plus >= {1'b0, FT_MAX});

  assign layer_accept = (state_q == LAYER) && !(|layer_start_q) && layer_done[cur_q];
  assign wd_expire    = (TIMEOUT > 0) && (state_q == LAYER) && !(|layer_start_q) &&
                        (wdog_q == WD_MAX) && !layer_accept;

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    cur_d         = cur_q;
    layer_start_d = '0;
    swap_start_d  = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    err_to_d      = err_clr ? '0 : err_to_q;

    case (state_q)
      PACE: begin
        if (pace_ok) begin
          mask_d = layer_en;
          if (nx_found) begin
            state_d               = LAYER;
            cur_d                 = nx_idx;
            layer_start_d[nx_idx] = 1'b1;
          end else begin
            state_d      = SWAP;
            cur_d        = '0;
            swap_start_d = 1'b1;
          end
        end
      end
      LAYER: begin
        if (layer_accept || wd_expire) begin
          if (wd_expire) begin
            err_to_d[cur_q] = 1'b1;
          end
          if (nx_found) begin
            cur_d                 = nx_idx;
            layer_start_d[nx_idx] = 1'b1;
          end else begin
            state_d      = SWAP;
            cur_d        = '0;
            swap_start_d = 1'b1;
          end
        end
      end
      SWAP: begin
        if (swap_done && !swap_start_q) begin
          frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
          state_d     = PACE;
        end
      end
      default: begin
        state_d = PACE;
        cur_d   = '0;
      end
    endcase

    busy_d = (state_d != PACE);

    if (swap_start_d) begin
      frame_tmr_d = '0;
    end else if (frame_tmr_q >= FT_MAX) begin
      frame_tmr_d = FT_MAX;
    end else begin
      frame_tmr_d = frame_tmr_q + FT_W'(1);
    end

    if ((TIMEOUT == 0) || (|layer_start_d) || (state_d != LAYER)) begin
      wdog_d = '0;
    end else if (wdog_q >= WD_MAX) begin
      wdog_d = WD_MAX;
    end else begin
      wdog_d = wdog_q + WD_W'(1);
    end
  end

  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= PACE;
      mask_q        <= '0;
      cur_q         <= '0;
      layer_start_q <= '0;
      swap_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      frame_cnt_q   <= '0;
      err_to_q      <= '0;
      frame_tmr_q   <= FT_MAX;
      wdog_q        <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      cur_q         <= cur_d;
      layer_start_q <= layer_start_d;
      swap_start_q  <= swap_start_d;
      busy_q        <= busy_d;
      frame_cnt_q   <= frame_cnt_d;
      err_to_q      <= err_to_d;
      frame_tmr_q   <= frame_tmr_d;
      wdog_q        <= wdog_d;
    end
  end

  assign layer_start = layer_start_q;
  assign swap_start  = swap_start_q;
  assign busy        = busy_q;
  assign cur_layer   = cur_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_to      = err_to_q;

endmodule

// File: tb/tb_disp_layer_seq.sv
// Scoreboard bench for disp_layer_seq: directed frames push expected pulses,
// a monitor pops and compares each start/swap pulse as it appears.
module tb_disp_layer_seq;

  localparam int N         = 4;
  localparam int MIN_FRAME = 100;
  localparam int TIMEOUT   = 50;

  logic          clkSYS     = 1'b0;
  logic          n_reset    = 1'b0;
  logic [N-1:0]  layer_en   = '0;
  logic [N-1:0]  layer_done = '0;
  logic          swap_done  = 1'b0;
  logic          err_clr    = 1'b0;
  logic [N-1:0]  layer_start;
  logic          swap_start;
  logic          busy;
  logic [1:0]    cur_layer;
  logic [15:0]   frame_cnt;
  logic [N-1:0]  err_to;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    logic [N:0] pulses;
    logic [1:0] cur;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  disp_layer_seq #(
    .N         (N),
    .MIN_FRAME (MIN_FRAME),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clkSYS      (clkSYS),
    .n_reset     (n_reset),
    .layer_en    (layer_en),
    .layer_start (layer_start),
    .layer_done  (layer_done),
    .swap_start  (swap_start),
    .swap_done   (swap_done),
    .err_clr     (err_clr),
    .busy        (busy),
    .cur_layer   (cur_layer),
    .frame_cnt   (frame_cnt),
    .err_to      (err_to)
  );

  always #5 clkSYS = ~clkSYS;

  always @(posedge clkSYS) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expectLayer(input int idx, input int at);
    exp_t e;
    e.pulses      = '0;
    e.pulses[idx] = 1'b1;
    e.cur         = 2'(idx);
    e.at          = at;
    exp_q.push_back(e);
  endtask

  task automatic expectSwap(input int at);
    exp_t e;
    e.pulses = {1'b1, {N{1'b0}}};
    e.cur    = 2'd0;
    e.at     = at;
    exp_q.push_back(e);
  endtask

  task automatic waitUntil(input int t);
    while (cyc < t) @(negedge clkSYS);
  endtask

  // Drives one-cycle input pulses during cycle 'at'; returns at cycle at+1.
  task automatic applyStimulus(input logic [N-1:0] done_v, input logic swap_v,
                               input logic clr_v, input int at);
    waitUntil(at);
    layer_done = done_v;
    swap_done  = swap_v;
    err_clr    = clr_v;
    @(negedge clkSYS);
    layer_done = '0;
    swap_done  = 1'b0;
    err_clr    = 1'b0;
  endtask

  // Layers 0..3 each answer 10 cycles after their start; yields swap cycle.
  task automatic runAllLayers(input int s0, output int sw_at);
    int s;
    s = s0;
    for (int i = 0; i < N; i++) begin
      if (i < N - 1) expectLayer(i + 1, s + 11);
      else           expectSwap(s + 11);
      applyStimulus(4'(1 << i), 1'b0, 1'b0, s + 10);
      s += 11;
    end
    sw_at = s;
  endtask

  always @(negedge clkSYS) begin
    if (n_reset && (swap_start || (|layer_start))) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_pulse", {27'b0, swap_start, layer_start}, 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("pulse_vec", {27'b0, swap_start, layer_start}, {27'b0, mon_e.pulses});
        checkOutput("pulse_cycle", cyc, mon_e.at);
        checkOutput("pulse_cur_layer", {30'b0, cur_layer}, {30'b0, mon_e.cur});
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] time limit exceeded");
  end

  initial begin
    int s, sw, r;

    repeat (3) @(negedge clkSYS);
    checkOutput("rst_layer_start", layer_start, 0);
    checkOutput("rst_swap_start", swap_start, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cur_layer", cur_layer, 0);
    checkOutput("rst_frame_cnt", frame_cnt, 0);
    checkOutput("rst_err_to", err_to, 0);

    // Full mask, first frame launches right after reset release.
    layer_en = 4'hF;
    r = cyc;
    expectLayer(0, r + 1);
    n_reset = 1'b1;
    runAllLayers(r + 1, sw);
    applyStimulus('0, 1'b1, 1'b0, sw + 2);
    checkOutput("t1_frame_cnt", frame_cnt, 1);

    // Sparse mask 0101.
    layer_en = 4'b0101;
    s = sw + 100;
    expectLayer(0, s);
    expectLayer(2, s + 11);
    applyStimulus(4'b0001, 1'b0, 1'b0, s + 10);
    s += 11;
    waitUntil(s + 5);
    checkOutput("t2_cur_layer2", cur_layer, 2);
    expectSwap(s + 11);
    applyStimulus(4'b0100, 1'b0, 1'b0, s + 10);
    sw = s + 11;

    // Empty mask: pacing alone sets the swap period.
    layer_en = 4'h0;
    expectSwap(sw + 100);
    applyStimulus('0, 1'b1, 1'b0, sw + 3);
    checkOutput("t2_frame_cnt", frame_cnt, 2);
    for (int k = 0; k < 2; k++) begin
      waitUntil(sw + 50);
      checkOutput("t3_busy_pace", busy, 0);
      sw += 100;
      waitUntil(sw + 1);
      checkOutput("t3_busy_swap", busy, 1);
      if (k == 0) expectSwap(sw + 100);
      applyStimulus('0, 1'b1, 1'b0, sw + 3);
      checkOutput("t3_frame_cnt", frame_cnt, 3 + k);
    end

    // Layer 1 never answers: watchdog aborts it.
    layer_en = 4'b0110;
    s = sw + 100;
    expectLayer(1, s);
    expectLayer(2, s + 51);
    waitUntil(s + 50);
    checkOutput("t4_err_before", err_to, 0);
    waitUntil(s + 51);
    checkOutput("t4_err_set", err_to, 4'b0010);
    s += 51;
    expectSwap(s + 11);
    applyStimulus(4'b0100, 1'b0, 1'b0, s + 10);
    sw = s + 11;
    applyStimulus('0, 1'b0, 1'b1, sw + 1);
    checkOutput("t4_err_clr", err_to, 0);
    applyStimulus('0, 1'b1, 1'b0, sw + 3);
    checkOutput("t4_frame_cnt", frame_cnt, 5);

    // Done in the expiry cycle wins over the watchdog.
    s = sw + 100;
    expectLayer(1, s);
    expectLayer(2, s + 51);
    applyStimulus(4'b0010, 1'b0, 1'b0, s + 50);
    checkOutput("t4_no_err", err_to, 0);
    s += 51;
    expectSwap(s + 11);
    applyStimulus(4'b0100, 1'b0, 1'b0, s + 10);
    sw = s + 11;
    applyStimulus('0, 1'b1, 1'b0, sw + 3);
    checkOutput("t4b_frame_cnt", frame_cnt, 6);

    // Mask change and stray done during layer 1.
    layer_en = 4'hF;
    s = sw + 100;
    expectLayer(0, s);
    expectLayer(1, s + 11);
    applyStimulus(4'b0001, 1'b0, 1'b0, s + 10);
    s += 11;
    applyStimulus(4'b1000, 1'b0, 1'b0, s + 2);
    layer_en = 4'h1;
    expectLayer(2, s + 11);
    applyStimulus(4'b0010, 1'b0, 1'b0, s + 10);
    s += 11;
    expectLayer(3, s + 11);
    applyStimulus(4'b0100, 1'b0, 1'b0, s + 10);
    s += 11;
    expectSwap(s + 11);
    applyStimulus(4'b1000, 1'b0, 1'b0, s + 10);
    sw = s + 11;
    applyStimulus('0, 1'b1, 1'b0, sw + 2);
    checkOutput("t6_frame_cnt", frame_cnt, 7);
    s = sw + 100;
    expectLayer(0, s);
    expectSwap(s + 11);
    applyStimulus(4'b0001, 1'b0, 1'b0, s + 10);
    sw = s + 11;
    applyStimulus('0, 1'b1, 1'b0, sw + 2);
    checkOutput("t6b_frame_cnt", frame_cnt, 8);

    // Reset while layer 2 is active.
    layer_en = 4'hF;
    s = sw + 100;
    expectLayer(0, s);
    expectLayer(1, s + 11);
    expectLayer(2, s + 22);
    applyStimulus(4'b0001, 1'b0, 1'b0, s + 10);
    applyStimulus(4'b0010, 1'b0, 1'b0, s + 21);
    waitUntil(s + 25);
    checkOutput("t5_cur_before", cur_layer, 2);
    n_reset = 1'b0;
    #1;
    checkOutput("t5_rst_layer_start", layer_start, 0);
    checkOutput("t5_rst_swap_start", swap_start, 0);
    checkOutput("t5_rst_busy", busy, 0);
    checkOutput("t5_rst_cur_layer", cur_layer, 0);
    checkOutput("t5_rst_frame_cnt", frame_cnt, 0);
    repeat (2) @(negedge clkSYS);
    r = cyc;
    expectLayer(0, r + 1);
    n_reset = 1'b1;
    waitUntil(r + 1);
    checkOutput("t5_frame_cnt_after", frame_cnt, 0);
    runAllLayers(r + 1, sw);
    applyStimulus('0, 1'b1, 1'b0, sw + 2);
    checkOutput("t5_frame_cnt_end", frame_cnt, 1);

    waitUntil(sw + 10);
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
